// File: rtl/sram_bus_ctrl.sv
// rtl/sram_bus_ctrl.sv - valid/ready core port to asynchronous SRAM bridge
// Splits each bus access into SRAM-width beats with setup/strobe/hold/turnaround timing.
module sram_bus_ctrl #(
  parameter int ADDR_W   = 17,
  parameter int SRAM_DW  = 16,
  parameter int BUS_DW   = 32,
  parameter int WAIT_CYC = 2,
  parameter int TURN_CYC = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_we,
  input  logic [ADDR_W+$clog2(SRAM_DW/8)-1:0]  req_addr,
  input  logic [BUS_DW-1:0]                    req_wdata,
  input  logic [BUS_DW/8-1:0]                  req_be,
  output logic                                 rsp_valid,
  output logic [BUS_DW-1:0]                    rsp_rdata,
  output logic                                 sram_cs1_n,
  output logic                                 sram_cs2,
  output logic                                 sram_oe_n,
  output logic                                 sram_we_n,
  output logic [SRAM_DW/8-1:0]                 sram_be_n,
  output logic [ADDR_W-1:0]                    sram_a,
  inout  wire  [SRAM_DW-1:0]                   sram_io
);

  localparam int NB     = BUS_DW / SRAM_DW;
  localparam int LANES  = SRAM_DW / 8;
  localparam int BE_W   = BUS_DW / 8;
  localparam int LB     = $clog2(SRAM_DW / 8);
  localparam int BA_W   = ADDR_W + LB;
  localparam int BEAT_W = $clog2(NB + 1);
  localparam int CNT_MX = (WAIT_CYC > TURN_CYC) ? WAIT_CYC : TURN_CYC;
  localparam int CNT_W  = $clog2(CNT_MX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_TURN, S_DONE
  } state_t;

  state_t              r_state, w_next_state;
  logic [BEAT_W-1:0]   r_beat, w_next_beat;
  logic [CNT_W-1:0]    r_cnt, w_next_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_base;
  logic [BUS_DW-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic [BUS_DW-1:0]   r_rbuf;
  logic [BUS_DW-1:0]   r_rdata;

  logic [ADDR_W-1:0]   w_req_base;
  logic [BEAT_W-1:0]   w_first_beat;
  logic [BEAT_W-1:0]   w_following_beat;
  logic                w_active;
  logic                w_accept;
  logic                w_last_strobe;
  logic [LANES-1:0]    w_lane_be;
  logic                w_unused_addr;

  // Index of the first beat at or after 'start' that must touch the SRAM; NB if none.
  // Write beats with no enabled byte lanes are skipped, read beats never are.
  function automatic logic [BEAT_W-1:0] find_beat(input logic we, input logic [BE_W-1:0] be,
                                                  input logic [BEAT_W-1:0] start);
    logic [BEAT_W-1:0] res;
    res = BEAT_W'(NB);
    for (int k = NB - 1; k >= 0; k--) begin
      if (k >= int'(start) && (!we || (|be[k*LANES +: LANES]))) res = BEAT_W'(k);
    end
    return res;
  endfunction

  assign w_req_base       = req_addr[BA_W-1:LB] & ~ADDR_W'(NB - 1);
  assign w_unused_addr    = ^req_addr;
  assign w_first_beat     = find_beat(req_we, req_be, '0);
  assign w_following_beat = find_beat(r_we, r_be, r_beat + BEAT_W'(1));
  assign w_accept         = (r_state == S_IDLE) && req_valid;
  assign w_last_strobe    = (r_state == S_STROBE) && (r_cnt == CNT_W'(WAIT_CYC - 1));

  always_comb begin
    w_next_state = r_state;
    w_next_beat  = r_beat;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_first_beat < BEAT_W'(NB)) begin
            w_next_state = S_SETUP;
            w_next_beat  = w_first_beat;
          end else begin
            w_next_state = S_DONE;
            w_next_beat  = '0;
          end
        end
      end
      S_SETUP: begin
        w_next_state = S_STROBE;
        w_next_cnt   = '0;
      end
      S_STROBE: begin
        if (w_last_strobe) w_next_state = S_HOLD;
        else               w_next_cnt   = r_cnt + CNT_W'(1);
      end
      S_HOLD: begin
        w_next_state = S_TURN;
        w_next_cnt   = '0;
      end
      S_TURN: begin
        if (r_cnt == CNT_W'(TURN_CYC - 1)) begin
          if (w_following_beat < BEAT_W'(NB)) begin
            w_next_state = S_SETUP;
            w_next_beat  = w_following_beat;
          end else begin
            w_next_state = S_DONE;
          end
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_base  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rbuf  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      r_beat  <= w_next_beat;
      r_cnt   <= w_next_cnt;
      if (w_accept) begin
        r_we    <= req_we;
        r_base  <= w_req_base;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
      if (w_last_strobe && !r_we) r_rbuf[r_beat*SRAM_DW +: SRAM_DW] <= sram_io;
      // Publish read data only as the access completes so rsp_rdata stays stable otherwise.
      if (r_state == S_TURN && w_next_state == S_DONE && !r_we) r_rdata <= r_rbuf;
    end
  end

  assign w_active  = (r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_HOLD);
  assign w_lane_be = r_be[r_beat*LANES +: LANES];

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_DONE);
  assign rsp_rdata  = r_rdata;
  assign sram_cs1_n = ~w_active;
  assign sram_cs2   = w_active;
  assign sram_oe_n  = ~((r_state == S_STROBE) && !r_we);
  assign sram_we_n  = ~((r_state == S_STROBE) && r_we);
  assign sram_be_n  = !w_active ? {LANES{1'b1}} : (r_we ? ~w_lane_be : {LANES{1'b0}});
  assign sram_a     = r_base + ADDR_W'(r_beat);
  assign sram_io    = (w_active && r_we) ? r_wdata[r_beat*SRAM_DW +: SRAM_DW] : {SRAM_DW{1'bz}};

endmodule
